// File: rtl/seq_dec.sv
// seq_dec: registered instruction decoder/sequencer for the 16-bit PU.
// Accepts one instruction per ov/ordy handshake and drives the datapath
// control bundle for exactly one cycle afterwards; RMW stores take two
// control cycles, HALT parks the sequencer until reset.
module seq_dec #(
   parameter int unsigned RAW    = 2,
   parameter int unsigned DW     = 16,
   parameter bit          RMW_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [15:0]     o,
   input  logic            ov,
   output logic            ordy,
   input  logic            stall,
   output logic            h,
   output logic            we,
   output logic [RAW-1:0]  wad,
   output logic [RAW-1:0]  ra,
   output logic [RAW-1:0]  rb,
   output logic [3:0]      op,
   output logic [1:0]      liop,
   output logic [7:0]      iv,
   output logic [DW-1:0]   ivx,
   output logic            dmwe,
   output logic            dms,
   output logic            pcwe,
   output logic            ill
);

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_THA = 4'hE;
   localparam logic [3:0] OP_THB = 4'hF;
   localparam logic [1:0] LI_IMM = 2'b10;
   localparam logic [1:0] LI_THU = 2'b11;

   typedef enum logic [1:0] {DEC, RMW1, RMW2, HLT} state_t;

   typedef struct packed {
      logic           h;
      logic           we;
      logic [RAW-1:0] wad;
      logic [RAW-1:0] ra;
      logic [RAW-1:0] rb;
      logic [3:0]     op;
      logic [1:0]     liop;
      logic [7:0]     iv;
      logic [DW-1:0]  ivx;
      logic           dmwe;
      logic           dms;
      logic           pcwe;
   } ctl_t;

   // Zero-fill a 2-bit register field to the register-address width.
   function automatic logic [RAW-1:0] rf(input logic [1:0] f);
      logic [RAW-1:0] r;
      r      = '0;
      r[1:0] = f;
      return r;
   endfunction

   function automatic ctl_t idle_ctl();
      ctl_t c;
      c      = '0;
      c.op   = OP_THB;
      c.liop = LI_THU;
      return c;
   endfunction

   state_t         state_q, state_d;
   ctl_t           ctl_q, ctl_d;
   ctl_t           dc;
   logic           d_rmw, d_halt, d_ill;
   logic           ill_q, ill_d;
   logic [7:0]     ir_q;
   logic           acc;
   logic [DW-1:0]  imm_s, imm_z;

   assign acc   = ov && (state_q == DEC) && !stall;
   assign imm_s = DW'($signed(o[7:0]));
   assign imm_z = DW'(o[7:0]);

   // Combinational decode of the presented instruction word.
   always_comb begin
      dc      = idle_ctl();
      dc.pcwe = 1'b1;
      d_rmw   = 1'b0;
      d_halt  = 1'b0;
      d_ill   = 1'b0;
      casez (o)
         16'b0000_0000_0000_???0: ;
         16'b0000_0000_0000_???1: begin
            d_halt  = 1'b1;
            dc.h    = 1'b1;
            dc.pcwe = 1'b0;
         end
         16'b0000_01??_????_????: begin
            dc.we = 1'b1; dc.wad = rf(o[9:8]); dc.liop = LI_IMM;
            dc.iv = o[7:0]; dc.ivx = imm_s;
         end
         16'b0000_10??_????_????: begin
            dc.dmwe = 1'b1; dc.rb = rf(o[9:8]); dc.liop = LI_IMM;
            dc.iv = o[7:0]; dc.ivx = imm_s;
         end
         16'b0010_00??_????_????: begin
            dc.we = 1'b1; dc.wad = rf(o[9:8]); dc.op = o[7:4];
            dc.ra = rf(o[3:2]); dc.rb = rf(o[1:0]);
         end
         16'b010?_????_????_????: begin
            dc.we = 1'b1; dc.wad = rf(o[11:10]); dc.rb = rf(o[9:8]);
            dc.liop = {1'b0, o[12]}; dc.iv = o[7:0]; dc.ivx = imm_z;
         end
         16'b0110_0010_????_????: begin
            dc.ra = rf(o[3:2]);
            if (RMW_EN && (o[7:4] != OP_THB)) begin
               // First RMW cycle only reads [ra]; the write happens in RMW2.
               d_rmw   = 1'b1;
               dc.dms  = 1'b1;
               dc.op   = OP_THA;
               dc.pcwe = 1'b0;
            end else begin
               dc.dmwe = 1'b1;
               dc.rb   = rf(o[1:0]);
            end
         end
         16'b1000_00??_????_????: begin
            dc.we = 1'b1; dc.dms = 1'b1; dc.wad = rf(o[9:8]);
            dc.liop = LI_IMM; dc.iv = o[7:0]; dc.ivx = imm_z;
         end
         16'b1001_????_????_????: begin
            dc.dmwe = 1'b1; dc.ra = rf(o[11:10]); dc.rb = rf(o[9:8]);
            dc.op = OP_ADD; dc.liop = LI_IMM; dc.iv = o[7:0]; dc.ivx = imm_s;
         end
         16'b1010_????_????_????: begin
            dc.we = 1'b1; dc.dms = 1'b1; dc.wad = rf(o[11:10]);
            dc.op = o[7:4]; dc.ra = rf(o[3:2]); dc.rb = rf(o[1:0]);
         end
         16'b1011_????_????_????: begin
            dc.we = 1'b1; dc.dms = 1'b1; dc.wad = rf(o[11:10]);
            dc.ra = rf(o[9:8]); dc.op = OP_ADD; dc.liop = LI_IMM;
            dc.iv = o[7:0]; dc.ivx = imm_s;
         end
         16'b110?_????_????_????: begin
            dc.we = 1'b1; dc.wad = rf(o[11:10]); dc.ra = rf(o[9:8]);
            dc.op = {3'b000, o[12]}; dc.liop = LI_IMM;
            dc.iv = o[7:0]; dc.ivx = imm_s;
         end
         default: d_ill = 1'b1;
      endcase
   end

   // State, control bundle and sticky flag registers; stall freezes all.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= DEC;
         ctl_q   <= idle_ctl();
         ill_q   <= 1'b0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ctl_q   <= ctl_d;
         ill_q   <= ill_d;
         if (acc)
            ir_q <= o[7:0];
      end
   end

   // Next-state selection.
   always_comb begin
      state_d = state_q;
      if (!stall) begin
         case (state_q)
            DEC:     if (acc) begin
                        if (d_halt)     state_d = HLT;
                        else if (d_rmw) state_d = RMW1;
                     end
            RMW1:    state_d = RMW2;
            RMW2:    state_d = DEC;
            HLT:     state_d = HLT;
            default: state_d = DEC;
         endcase
      end
   end

   // Next control bundle, ready and illegal flag.
   always_comb begin
      ctl_d = ctl_q;
      ill_d = ill_q;
      ordy  = (state_q == DEC) && !stall;
      if (!stall) begin
         case (state_q)
            DEC: begin
               if (acc) begin
                  ctl_d = dc;
                  ill_d = ill_q | d_ill;
               end else begin
                  ctl_d = idle_ctl();
               end
            end
            RMW1: begin
               ctl_d      = idle_ctl();
               ctl_d.dmwe = 1'b1;
               ctl_d.dms  = 1'b1;
               ctl_d.ra   = rf(ir_q[3:2]);
               ctl_d.rb   = rf(ir_q[1:0]);
               ctl_d.op   = ir_q[7:4];
               ctl_d.pcwe = 1'b1;
            end
            HLT: begin
               ctl_d   = idle_ctl();
               ctl_d.h = 1'b1;
            end
            default: ctl_d = idle_ctl();
         endcase
      end
   end

   assign h    = ctl_q.h;
   assign we   = ctl_q.we;
   assign wad  = ctl_q.wad;
   assign ra   = ctl_q.ra;
   assign rb   = ctl_q.rb;
   assign op   = ctl_q.op;
   assign liop = ctl_q.liop;
   assign iv   = ctl_q.iv;
   assign ivx  = ctl_q.ivx;
   assign dmwe = ctl_q.dmwe;
   assign dms  = ctl_q.dms;
   assign pcwe = ctl_q.pcwe;
   assign ill  = ill_q;

endmodule
